// File: rtl/accelerator_dma.sv
// accelerator_dma: bus initiator that copies IN_WORDS operand words from
// src_addr into the accelerator write window, then OUT_WORDS result words
// from the accelerator read window to dst_addr, one word at a time.
// Ports: clk, rst (async, active-high); start/src_addr/dst_addr job request;
// busy/done/error job status; mem_valid/mem_ready/mem_addr/mem_wdata/
// mem_wstrb/mem_rdata shared bus initiator interface.
// Optional: define ACCELERATOR_DMA_TIMEOUT_EN to abort a job when a transfer
// waits TIMEOUT cycles for mem_ready (error then reports the abort).
module accelerator_dma #(
  parameter logic [31:0] ACC_WRITE = 32'h0110_0000,
  parameter logic [31:0] ACC_READ  = 32'h0130_0000,
  parameter int unsigned IN_WORDS  = 18,
  parameter int unsigned OUT_WORDS = 4,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] src_addr,
  input  logic [31:0] dst_addr,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata
);

  localparam int KW = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_GAP,
    S_WR_REQ,
    S_WR_GAP,
    S_FIN
  } state_e;

  state_e        state_q, state_d;
  logic          phase_q, phase_d;
  logic [KW-1:0] k_q, k_d;
  logic [31:0]   src_q, src_d;
  logic [31:0]   dst_q, dst_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          valid_q, valid_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    wstrb_q, wstrb_d;
  logic          last_in, last_out;

  // Base address low bits are dropped, so they are intentionally unused.
  logic unused_lsbs;
  assign unused_lsbs = ^{src_addr[1:0], dst_addr[1:0]};

  function automatic logic [31:0] woff(input logic [KW-1:0] k);
    return {{(30-KW){1'b0}}, k, 2'b00};
  endfunction

  assign last_in  = (k_q == KW'(IN_WORDS - 1));
  assign last_out = (k_q == KW'(OUT_WORDS - 1));

`ifdef ACCELERATOR_DMA_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  logic        error_q, error_d;
  logic        abort;
`else
  localparam int unsigned unused_timeout = TIMEOUT;
`endif

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    k_d     = k_q;
    src_d   = src_q;
    dst_d   = dst_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    valid_d = valid_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
`ifdef ACCELERATOR_DMA_TIMEOUT_EN
    cnt_d   = cnt_q;
    error_d = error_q;
    abort   = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          src_d   = {src_addr[31:2], 2'b00};
          dst_d   = {dst_addr[31:2], 2'b00};
          phase_d = 1'b0;
          k_d     = '0;
          busy_d  = 1'b1;
          valid_d = 1'b1;
          wstrb_d = 4'h0;
          addr_d  = {src_addr[31:2], 2'b00};
          state_d = S_RD_REQ;
`ifdef ACCELERATOR_DMA_TIMEOUT_EN
          cnt_d   = '0;
          error_d = 1'b0;
`endif
        end
      end
      S_RD_REQ: begin
        if (mem_ready) begin
          wdata_d = mem_rdata;
          valid_d = 1'b0;
          state_d = S_RD_GAP;
        end
`ifdef ACCELERATOR_DMA_TIMEOUT_EN
        else if (cnt_q == 16'(TIMEOUT - 1)) abort = 1'b1;
        else cnt_d = cnt_q + 16'd1;
`endif
      end
      // Gaps wait out the responder's held ready before the next request.
      S_RD_GAP: begin
        if (!mem_ready) begin
          valid_d = 1'b1;
          wstrb_d = 4'hF;
          addr_d  = phase_q ? dst_q + woff(k_q)
                            : ACC_WRITE + woff(k_q);
          state_d = S_WR_REQ;
`ifdef ACCELERATOR_DMA_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      S_WR_REQ: begin
        if (mem_ready) begin
          valid_d = 1'b0;
          state_d = S_WR_GAP;
        end
`ifdef ACCELERATOR_DMA_TIMEOUT_EN
        else if (cnt_q == 16'(TIMEOUT - 1)) abort = 1'b1;
        else cnt_d = cnt_q + 16'd1;
`endif
      end
      S_WR_GAP: begin
        if (!mem_ready) begin
          if (phase_q && last_out) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_FIN;
          end else begin
            if (!phase_q && last_in) begin
              phase_d = 1'b1;
              k_d     = '0;
            end else begin
              k_d = k_q + KW'(1);
            end
            valid_d = 1'b1;
            wstrb_d = 4'h0;
            addr_d  = phase_d ? ACC_READ + woff(k_d)
                              : src_q + woff(k_d);
            state_d = S_RD_REQ;
`ifdef ACCELERATOR_DMA_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end
      end
      S_FIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
`ifdef ACCELERATOR_DMA_TIMEOUT_EN
    if (abort) begin
      valid_d = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b1;
      error_d = 1'b1;
      state_d = S_FIN;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      phase_q <= 1'b0;
      k_q     <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      k_q     <= k_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
    end
  end

`ifdef ACCELERATOR_DMA_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      error_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      error_q <= error_d;
    end
  end
  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  assign busy      = busy_q;
  assign done      = done_q;
  assign mem_valid = valid_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wstrb = wstrb_q;

endmodule

// File: tb/tb_accelerator_dma.sv
// tb_accelerator_dma: scoreboard bench for accelerator_dma with a
// registered-ready memory responder; expected transfers queued per job.
module tb_accelerator_dma;

  localparam logic [31:0] ACC_WRITE = 32'h0110_0000;
  localparam logic [31:0] ACC_READ  = 32'h0130_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] src_addr = '0;
  logic [31:0] dst_addr = '0;
  logic        busy, done, error;
  logic        mem_valid, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  accelerator_dma dut (
    .clk(clk), .rst(rst), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr),
    .busy(busy), .done(done), .error(error),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  function automatic void check(input bit ok, input string name,
                                input logic [31:0] act,
                                input logic [31:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endfunction

  // Responder: registered ready, held one extra cycle.
  logic [31:0] mem [logic [31:0]];
  int          waits = 0;
  logic [31:0] nack_addr = 32'hFFFF_FFFF;
  logic        rdy, hold;
  int          wcnt;
  logic [31:0] rdata;
  assign mem_ready = rdy;
  assign mem_rdata = rdata;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'hBAD0_0000;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy <= 1'b0; hold <= 1'b0; wcnt <= 0; rdata <= '0;
    end else if (rdy && !hold) begin
      hold <= 1'b1;
    end else if (rdy) begin
      rdy <= 1'b0; hold <= 1'b0;
    end else if (mem_valid && mem_addr != nack_addr) begin
      if (wcnt >= waits) begin
        wcnt <= 0;
        rdy  <= 1'b1;
        if (mem_wstrb == 4'hF) mem[mem_addr] = mem_wdata;
        else rdata <= mem_rd(mem_addr);
      end else begin
        wcnt <= wcnt + 1;
      end
    end
  end

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] data;
  } xfer_t;
  xfer_t sbq[$];

  function automatic void push_x(input logic [31:0] a,
                                 input logic [3:0] s,
                                 input logic [31:0] d);
    xfer_t x;
    x.addr = a; x.wstrb = s; x.data = d;
    sbq.push_back(x);
  endfunction

  function automatic void preload(input logic [31:0] base);
    for (int k = 0; k < 18; k++) mem[base + 4*k] = 32'h100 + k;
  endfunction

  function automatic void push_job(input logic [31:0] s,
                                   input logic [31:0] d);
    for (int k = 0; k < 18; k++) begin
      push_x(s + 4*k, 4'h0, 0);
      push_x(ACC_WRITE + 4*k, 4'hF, 32'h100 + k);
    end
    for (int j = 0; j < 4; j++) begin
      push_x(ACC_READ + 4*j, 4'h0, 0);
      push_x(d + 4*j, 4'hF, 32'hA000 + j);
    end
  endfunction

  // Monitor: pops on every accepted transfer; watches bus stability.
  logic        pv = 1'b0;
  logic [31:0] pa, pd;
  logic [3:0]  ps;
  always @(negedge clk) begin
    if (rst) begin
      pv = 1'b0;
    end else begin
      if (mem_valid && mem_ready) begin
        check(sbq.size() > 0, "xfer_expected", mem_addr, 0);
        if (sbq.size() > 0) begin
          xfer_t e;
          e = sbq.pop_front();
          check(mem_addr == e.addr, "xfer_addr", mem_addr, e.addr);
          check(mem_wstrb == e.wstrb, "xfer_wstrb", 32'(mem_wstrb), 32'(e.wstrb));
          if (e.wstrb == 4'hF)
            check(mem_wdata == e.data, "xfer_wdata", mem_wdata, e.data);
        end
      end
      if (pv && mem_valid) begin
        if (mem_addr != pa || mem_wdata != pd || mem_wstrb != ps)
          check(1'b0, "bus_stable", mem_addr, pa);
      end
      if (!pv && mem_valid)
        check(!mem_ready, "valid_rise_on_ready", 32'(mem_ready), 0);
      pv = mem_valid; pa = mem_addr; pd = mem_wdata; ps = mem_wstrb;
    end
  end

  int t0;

  task automatic do_start(input logic [31:0] s, input logic [31:0] d);
    @(negedge clk);
    start = 1'b1; src_addr = s; dst_addr = d;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    src_addr = 32'h9000; dst_addr = 32'h9100;
  endtask

  task automatic wait_done(input int exp_cyc, input bit poke,
                           input bit exp_err, input string nm);
    int n = 0;
    int busy_n = 0;
    bit seen = 0;
    while (n < 3000) begin
      if (poke) start = (cyc - t0 == 5) || (cyc - t0 == 100);
      if (done) begin seen = 1; break; end
      if (busy) busy_n++;
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check(seen, {nm, "_done_seen"}, 32'(seen), 1);
    if (seen) begin
      check(cyc - t0 == exp_cyc, {nm, "_done_cyc"}, cyc - t0, exp_cyc);
      check(busy_n == exp_cyc - 1, {nm, "_busy_cycles"}, busy_n, exp_cyc - 1);
      check(busy == 1'b0, {nm, "_busy_at_done"}, 32'(busy), 0);
      check(error == exp_err, {nm, "_error"}, 32'(error), 32'(exp_err));
      @(negedge clk);
      check(done == 1'b0, {nm, "_done_pulse"}, 32'(done), 0);
    end
    check(sbq.size() == 0, {nm, "_all_xfers"}, sbq.size(), 0);
  endtask

  initial begin
    for (int j = 0; j < 4; j++) mem[ACC_READ + 4*j] = 32'hA000 + j;
    preload(32'h1000);
    preload(32'h2000);

    #12;
    check(busy == 0, "rst_busy", 32'(busy), 0);
    check(done == 0, "rst_done", 32'(done), 0);
    check(error == 0, "rst_error", 32'(error), 0);
    check(mem_valid == 0, "rst_valid", 32'(mem_valid), 0);
    check(mem_addr == 0, "rst_addr", mem_addr, 0);
    check(mem_wdata == 0, "rst_wdata", mem_wdata, 0);
    check(mem_wstrb == 0, "rst_wstrb", 32'(mem_wstrb), 0);
    @(negedge clk);
    rst = 1'b0;

    // Zero-wait job.
    push_job(32'h1000, 32'h5000);
    do_start(32'h1000, 32'h5000);
    wait_done(177, 0, 0, "t1");
    for (int j = 0; j < 4; j++)
      check(mem_rd(32'h5000 + 4*j) == 32'hA000 + j, "t1_dst_mem",
            mem_rd(32'h5000 + 4*j), 32'hA000 + j);

    // Three wait states per transfer: 44 transfers of 7 cycles.
    waits = 3;
    push_job(32'h1000, 32'h6000);
    do_start(32'h1000, 32'h6000);
    wait_done(309, 0, 0, "t2");
    waits = 0;

    // Starts during a job are ignored.
    push_job(32'h1000, 32'h5000);
    do_start(32'h1000, 32'h5000);
    wait_done(177, 1, 0, "t3");
    begin
      int extra = 0;
      repeat (30) begin
        @(negedge clk);
        if (done) extra++;
      end
      check(extra == 0, "t3_single_done", extra, 0);
    end

    // Reset mid-transfer.
    push_job(32'h1000, 32'h5000);
    do_start(32'h1000, 32'h5000);
    while (cyc - t0 < 50) @(negedge clk);
    check(mem_valid == 1, "t4_valid_before_rst", 32'(mem_valid), 1);
    #1 rst = 1'b1;
    #1;
    check(mem_valid == 0, "t4_rst_valid", 32'(mem_valid), 0);
    check(busy == 0, "t4_rst_busy", 32'(busy), 0);
    sbq.delete();
    begin
      int dn = 0;
      repeat (3) begin
        @(negedge clk);
        if (done) dn++;
      end
      check(dn == 0, "t4_no_done", dn, 0);
    end
    rst = 1'b0;
    push_job(32'h1000, 32'h5000);
    do_start(32'h1000, 32'h5000);
    wait_done(177, 0, 0, "t4b");

`ifdef ACCELERATOR_DMA_TIMEOUT_EN
    // Third read never acknowledged: aborts after 255 waiting cycles.
    nack_addr = 32'h1008;
    push_x(32'h1000, 4'h0, 0);
    push_x(ACC_WRITE, 4'hF, 32'h100);
    push_x(32'h1004, 4'h0, 0);
    push_x(ACC_WRITE + 4, 4'hF, 32'h101);
    do_start(32'h1000, 32'h5000);
    wait_done(272, 0, 1, "t5");
    check(error == 1, "t5_error_held", 32'(error), 1);
    nack_addr = 32'hFFFF_FFFF;
    push_job(32'h1000, 32'h5000);
    do_start(32'h1000, 32'h5000);
    wait_done(177, 0, 0, "t5b");
`endif

    // Unaligned bases are forced to word alignment.
    push_job(32'h2000, 32'h3000);
    do_start(32'h2003, 32'h3002);
    wait_done(177, 0, 0, "t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
